// File: rtl/maxnet_engine.sv
// Fixed-point winner-take-all engine: loads N activations, applies lateral
// inhibition once per clock until at most one channel survives. Optional
// iteration limit is compiled in with MAXNET_TIMEOUT_EN.
module maxnet_engine #(
  parameter int N        = 4,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           eps,
  input  logic [N*WIDTH-1:0]         x_in,
  output logic                       busy,
  output logic                       done,
  output logic                       winner_valid,
  output logic [$clog2(N)-1:0]       winner_idx,
  output logic [WIDTH-1:0]           winner_val,
  output logic [CNT_W-1:0]           iter_count,
  output logic                       timeout
);
  localparam int IDX_W  = $clog2(N);
  localparam int SUM_W  = WIDTH + $clog2(N);
  localparam int PROD_W = WIDTH + SUM_W;

  // Handshake: start is a one-cycle request honoured only while busy=0;
  // done stays high until the next accepted start or rst.
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q [N];
  logic [WIDTH-1:0]   x_d [N];
  logic [WIDTH-1:0]   x_upd [N];
  logic [WIDTH-1:0]   eps_q, eps_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wv_q, wv_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [WIDTH-1:0]   wval_q, wval_d;

  logic [SUM_W-1:0]   total;
  logic [IDX_W:0]     nz_cnt;
  logic [IDX_W-1:0]   sole_idx, max_idx;
  logic [WIDTH-1:0]   sole_val, max_val;
  logic [SUM_W-1:0]   others [N];
  logic [PROD_W-1:0]  p_shr [N];

  generate
    if (CNT_W < $clog2(MAX_ITER + 1)) begin : g_cnt_w_too_small
    end
  endgenerate

  always_comb begin
    total    = '0;
    nz_cnt   = '0;
    sole_idx = '0;
    sole_val = '0;
    max_idx  = '0;
    max_val  = x_q[0];
    for (int i = 0; i < N; i++) begin
      total  = total + SUM_W'(x_q[i]);
      nz_cnt = nz_cnt + {{IDX_W{1'b0}}, (x_q[i] != '0)};
      if (x_q[i] != '0) begin
        sole_idx = IDX_W'(i);
        sole_val = x_q[i];
      end
      // Strict compare keeps the lowest index on equal maxima.
      if (x_q[i] > max_val) begin
        max_idx = IDX_W'(i);
        max_val = x_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      others[i] = total - SUM_W'(x_q[i]);
      p_shr[i]  = (PROD_W'(eps_q) * PROD_W'(others[i])) >> FRAC;
      x_upd[i]  = (p_shr[i] >= PROD_W'(x_q[i])) ? '0 : x_q[i] - WIDTH'(p_shr[i]);
    end
  end

`ifdef MAXNET_TIMEOUT_EN
  logic to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    eps_d   = eps_q;
    cnt_d   = cnt_q;
    wv_d    = wv_q;
    widx_d  = widx_q;
    wval_d  = wval_q;
`ifdef MAXNET_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          for (int i = 0; i < N; i++) x_d[i] = x_in[i*WIDTH +: WIDTH];
          eps_d   = eps;
          cnt_d   = '0;
          wv_d    = 1'b0;
          widx_d  = '0;
          wval_d  = '0;
`ifdef MAXNET_TIMEOUT_EN
          to_d    = 1'b0;
`endif
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (nz_cnt <= (IDX_W+1)'(1)) begin
          state_d = S_DONE;
          wv_d    = (nz_cnt == (IDX_W+1)'(1));
          widx_d  = sole_idx;
          wval_d  = sole_val;
        end
`ifdef MAXNET_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_ITER)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          wv_d    = 1'b0;
          widx_d  = max_idx;
          wval_d  = max_val;
        end
`endif
        else begin
          x_d   = x_upd;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      eps_q   <= '0;
      cnt_q   <= '0;
      wv_q    <= 1'b0;
      widx_q  <= '0;
      wval_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      eps_q   <= eps_d;
      cnt_q   <= cnt_d;
      wv_q    <= wv_d;
      widx_q  <= widx_d;
      wval_q  <= wval_d;
    end
  end

`ifdef MAXNET_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) to_q <= 1'b0;
    else     to_q <= to_d;
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy         = (state_q == S_ITER);
  assign done         = (state_q == S_DONE);
  assign winner_valid = wv_q;
  assign winner_idx   = widx_q;
  assign winner_val   = wval_q;
  assign iter_count   = cnt_q;
endmodule
